// File: rtl/game_state_ctrl.sv
// Match-level controller: start/score/timer/winner sequencing for one match.
// All outputs are registered; the prescaler provides the one-second timebase.
module game_state_ctrl #(
   parameter int TICK_DIV      = 25_000_000,
   parameter int MATCH_SECONDS = 90,
   parameter int WIN_SCORE     = 10,
   parameter int HOLD_SECONDS  = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_start,
   input  logic       goal_p1,
   input  logic       goal_p2,
   input  logic       snitch_p1,
   input  logic       snitch_p2,
   output logic       playing_reg,
   output logic       gameover_reg,
   output logic [6:0] score_p1,
   output logic [6:0] score_p2,
   output logic [6:0] time_left,
   output logic [1:0] winner,
   output logic       sec_tick
);

   // state      | meaning
   // S_IDLE     | after reset, waiting for the first start edge
   // S_PLAYING  | match running: clock counts down, events credited
   // S_GAMEOVER | results frozen; restart allowed once the hold time has elapsed

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int HW = $clog2(HOLD_SECONDS + 1);
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [HW-1:0] HOLD_LD    = HW'(HOLD_SECONDS);
   localparam logic [6:0]    MATCH_LD   = 7'(MATCH_SECONDS);
   localparam logic [6:0]    WIN_LD     = 7'(WIN_SCORE);
   localparam logic [6:0]    SCORE_MAX  = 7'd99;

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_PLAYING  = 2'd1,
      S_GAMEOVER = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;

   logic            r_btn_prev;
   logic [PW-1:0]   r_presc;
   logic [HW-1:0]   r_hold;
   logic            r_playing;
   logic            r_gameover;
   logic [6:0]      r_score_p1;
   logic [6:0]      r_score_p2;
   logic [6:0]      r_time_left;
   logic [1:0]      r_winner;
   logic            r_sec_tick;

   logic            w_start_edge;
   logic            w_wrap;
   logic            w_hold_done;
   logic            w_time_zero;
   logic [2:0]      w_add_p1;
   logic [2:0]      w_add_p2;
   logic [7:0]      w_sum_p1;
   logic [7:0]      w_sum_p2;
   logic [6:0]      w_upd_p1;
   logic [6:0]      w_upd_p2;
   logic            w_end;
   logic            w_enter_play;
   logic            w_enter_over;

   logic            w_playing_nxt;
   logic            w_gameover_nxt;
   logic            w_sec_tick_nxt;
   logic [1:0]      w_winner_nxt;

   assign w_start_edge = btn_start & ~r_btn_prev;
   assign w_wrap       = (r_presc == PRESC_LAST);
   assign w_hold_done  = (r_hold >= HOLD_LD);
   assign w_time_zero  = (r_time_left == 7'd0);

   // A goal is worth 1, a snitch 3; a cycle may carry both for the same player.
   assign w_add_p1 = (goal_p1 ? 3'd1 : 3'd0) + (snitch_p1 ? 3'd3 : 3'd0);
   assign w_add_p2 = (goal_p2 ? 3'd1 : 3'd0) + (snitch_p2 ? 3'd3 : 3'd0);
   assign w_sum_p1 = {1'b0, r_score_p1} + {5'd0, w_add_p1};
   assign w_sum_p2 = {1'b0, r_score_p2} + {5'd0, w_add_p2};
   assign w_upd_p1 = (w_sum_p1 > {1'b0, SCORE_MAX}) ? SCORE_MAX : w_sum_p1[6:0];
   assign w_upd_p2 = (w_sum_p2 > {1'b0, SCORE_MAX}) ? SCORE_MAX : w_sum_p2[6:0];

   assign w_end = w_time_zero | snitch_p1 | snitch_p2 |
                  (w_upd_p1 >= WIN_LD) | (w_upd_p2 >= WIN_LD);

   assign w_enter_play = (w_state_nxt == S_PLAYING) & (r_state != S_PLAYING);
   assign w_enter_over = (w_state_nxt == S_GAMEOVER) & (r_state == S_PLAYING);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_start_edge) w_state_nxt = S_PLAYING;
         end
         S_PLAYING: begin
            if (w_end) w_state_nxt = S_GAMEOVER;
         end
         S_GAMEOVER: begin
            if (w_start_edge && w_hold_done) w_state_nxt = S_PLAYING;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Next values for the registered outputs; a tick never lands in GAMEOVER.
   always_comb begin
      w_playing_nxt  = (w_state_nxt == S_PLAYING);
      w_gameover_nxt = (w_state_nxt == S_GAMEOVER);
      w_sec_tick_nxt = (r_state == S_PLAYING) & (w_state_nxt == S_PLAYING) & w_wrap;
      w_winner_nxt   = r_winner;
      if (w_enter_play) begin
         w_winner_nxt = 2'b00;
      end else if (w_enter_over) begin
         if (w_upd_p1 > w_upd_p2)      w_winner_nxt = 2'b01;
         else if (w_upd_p2 > w_upd_p1) w_winner_nxt = 2'b10;
         else                          w_winner_nxt = 2'b11;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_btn_prev  <= 1'b0;
         r_presc     <= '0;
         r_hold      <= '0;
         r_playing   <= 1'b0;
         r_gameover  <= 1'b0;
         r_score_p1  <= 7'd0;
         r_score_p2  <= 7'd0;
         r_time_left <= MATCH_LD;
         r_winner    <= 2'b00;
         r_sec_tick  <= 1'b0;
      end else begin
         r_btn_prev <= btn_start;
         r_playing  <= w_playing_nxt;
         r_gameover <= w_gameover_nxt;
         r_winner   <= w_winner_nxt;
         r_sec_tick <= w_sec_tick_nxt;

         if (w_enter_play) begin
            r_presc <= '0;
         end else if (r_state == S_IDLE) begin
            r_presc <= '0;
         end else if (w_wrap) begin
            r_presc <= '0;
         end else begin
            r_presc <= r_presc + 1'b1;
         end

         if (r_state != S_GAMEOVER || w_enter_play) begin
            r_hold <= '0;
         end else if (w_wrap && !w_hold_done) begin
            r_hold <= r_hold + 1'b1;
         end

         if (w_enter_play) begin
            r_score_p1  <= 7'd0;
            r_score_p2  <= 7'd0;
            r_time_left <= MATCH_LD;
         end else if (r_state == S_PLAYING) begin
            r_score_p1 <= w_upd_p1;
            r_score_p2 <= w_upd_p2;
            if (w_wrap && !w_time_zero) r_time_left <= r_time_left - 7'd1;
         end
      end
   end

   assign playing_reg  = r_playing;
   assign gameover_reg = r_gameover;
   assign score_p1     = r_score_p1;
   assign score_p2     = r_score_p2;
   assign time_left    = r_time_left;
   assign winner       = r_winner;
   assign sec_tick     = r_sec_tick;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Directed bench for game_state_ctrl with a short timebase (4 cycles per second).
// A vector table covers the timed-out match and hold/restart; hand sequences cover scoring.
module tb_game_state_ctrl;

   localparam int TD = 4;
   localparam int MS = 3;
   localparam int WS = 5;
   localparam int HS = 2;

   logic       clk = 1'b0;
   logic       reset;
   logic       btn_start, goal_p1, goal_p2, snitch_p1, snitch_p2;
   logic       playing_reg, gameover_reg, sec_tick;
   logic [6:0] score_p1, score_p2, time_left;
   logic [1:0] winner;

   int n_checks = 0;
   int n_fail   = 0;

   game_state_ctrl #(
      .TICK_DIV(TD), .MATCH_SECONDS(MS), .WIN_SCORE(WS), .HOLD_SECONDS(HS)
   ) dut (
      .clk(clk), .reset(reset), .btn_start(btn_start),
      .goal_p1(goal_p1), .goal_p2(goal_p2), .snitch_p1(snitch_p1), .snitch_p2(snitch_p2),
      .playing_reg(playing_reg), .gameover_reg(gameover_reg),
      .score_p1(score_p1), .score_p2(score_p2), .time_left(time_left),
      .winner(winner), .sec_tick(sec_tick)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       btn, g1, g2, s1, s2;
      logic       e_play, e_go;
      logic [6:0] e_sc1, e_sc2, e_t;
      logic [1:0] e_w;
      logic       e_tk;
   } vec_t;

   vec_t vecs[24];

   function automatic vec_t mk(input int btn, input int g1, input int g2, input int s1,
                               input int s2, input int play, input int go, input int sc1,
                               input int sc2, input int t, input int w, input int tk);
      vec_t v;
      v.btn = btn[0]; v.g1 = g1[0]; v.g2 = g2[0]; v.s1 = s1[0]; v.s2 = s2[0];
      v.e_play = play[0]; v.e_go = go[0];
      v.e_sc1 = sc1[6:0]; v.e_sc2 = sc2[6:0]; v.e_t = t[6:0];
      v.e_w = w[1:0]; v.e_tk = tk[0];
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input int play, input int go, input int sc1,
                            input int sc2, input int t, input int w, input int tk);
      chk($sformatf("%s.playing", tag), 32'(playing_reg), play);
      chk($sformatf("%s.gameover", tag), 32'(gameover_reg), go);
      chk($sformatf("%s.score_p1", tag), 32'(score_p1), sc1);
      chk($sformatf("%s.score_p2", tag), 32'(score_p2), sc2);
      chk($sformatf("%s.time_left", tag), 32'(time_left), t);
      chk($sformatf("%s.winner", tag), 32'(winner), w);
      chk($sformatf("%s.sec_tick", tag), 32'(sec_tick), tk);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_events();
      goal_p1 = 1'b0; goal_p2 = 1'b0; snitch_p1 = 1'b0; snitch_p2 = 1'b0;
   endtask

   // Wait out the hold time in GAMEOVER, then start a new match.
   task automatic restart(input string tag, input logic keep_btn);
      btn_start = 1'b0;
      repeat (12) cyc();
      btn_start = 1'b1;
      cyc();
      check_all(tag, 1, 0, 0, 0, MS, 0, 0);
      btn_start = keep_btn;
   endtask

   task automatic wait_gameover(input string tag, input int budget);
      int k;
      k = 0;
      while (!gameover_reg && k < budget) begin
         cyc();
         k++;
      end
      chk(tag, 32'(gameover_reg), 1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      vecs[0]  = mk(0,1,0,0,0, 0,0,0,0,3,0,0);
      vecs[1]  = mk(1,0,0,0,0, 1,0,0,0,3,0,0);
      vecs[2]  = mk(0,0,0,0,0, 1,0,0,0,3,0,0);
      vecs[3]  = mk(0,0,0,0,0, 1,0,0,0,3,0,0);
      vecs[4]  = mk(0,0,0,0,0, 1,0,0,0,3,0,0);
      vecs[5]  = mk(0,0,0,0,0, 1,0,0,0,2,0,1);
      vecs[6]  = mk(0,0,0,0,0, 1,0,0,0,2,0,0);
      vecs[7]  = mk(0,0,0,0,0, 1,0,0,0,2,0,0);
      vecs[8]  = mk(0,0,0,0,0, 1,0,0,0,2,0,0);
      vecs[9]  = mk(0,0,0,0,0, 1,0,0,0,1,0,1);
      vecs[10] = mk(0,0,0,0,0, 1,0,0,0,1,0,0);
      vecs[11] = mk(0,0,0,0,0, 1,0,0,0,1,0,0);
      vecs[12] = mk(0,0,0,0,0, 1,0,0,0,1,0,0);
      vecs[13] = mk(0,0,0,0,0, 1,0,0,0,0,0,1);
      vecs[14] = mk(0,0,0,0,0, 0,1,0,0,0,3,0);
      vecs[15] = mk(1,0,0,0,0, 0,1,0,0,0,3,0);
      vecs[16] = mk(0,0,0,1,0, 0,1,0,0,0,3,0);
      vecs[17] = mk(0,0,0,0,0, 0,1,0,0,0,3,0);
      vecs[18] = mk(1,0,0,0,0, 0,1,0,0,0,3,0);
      vecs[19] = mk(0,0,0,0,0, 0,1,0,0,0,3,0);
      vecs[20] = mk(0,0,0,0,0, 0,1,0,0,0,3,0);
      vecs[21] = mk(0,0,0,0,0, 0,1,0,0,0,3,0);
      vecs[22] = mk(1,0,0,0,0, 1,0,0,0,3,0,0);
      vecs[23] = mk(1,0,0,0,0, 1,0,0,0,3,0,0);

      reset = 1'b1;
      btn_start = 1'b0;
      clear_events();
      cyc();
      cyc();
      reset = 1'b0;
      cyc();
      check_all("reset", 0, 0, 0, 0, MS, 0, 0);

      // Timed-out draw, early start ignored in hold, restart after hold.
      for (int i = 0; i < 24; i++) begin
         btn_start = vecs[i].btn;
         goal_p1   = vecs[i].g1;
         goal_p2   = vecs[i].g2;
         snitch_p1 = vecs[i].s1;
         snitch_p2 = vecs[i].s2;
         cyc();
         clear_events();
         check_all($sformatf("v%0d", i), vecs[i].e_play, vecs[i].e_go, vecs[i].e_sc1,
                   vecs[i].e_sc2, vecs[i].e_t, vecs[i].e_w, vecs[i].e_tk);
      end

      // Simultaneous goals, then a snitch ends the match.
      btn_start = 1'b0;
      goal_p1 = 1'b1; goal_p2 = 1'b1;
      cyc();
      clear_events();
      check_all("both_goals", 1, 0, 1, 1, 3, 0, 0);
      snitch_p2 = 1'b1;
      cyc();
      clear_events();
      check_all("snitch_p2", 0, 1, 1, 4, 3, 2, 0);
      goal_p1 = 1'b1;
      cyc();
      clear_events();
      check_all("go_goal_ignored", 0, 1, 1, 4, 3, 2, 0);
      repeat (10) cyc();
      check_all("go_frozen", 0, 1, 1, 4, 3, 2, 0);

      // Five goals reach the win score.
      restart("restart1", 1'b0);
      for (int i = 1; i <= 5; i++) begin
         goal_p1 = 1'b1;
         cyc();
         clear_events();
         if (i < 4)
            check_all($sformatf("goal%0d", i), 1, 0, i, 0, 3, 0, 0);
         else if (i == 4)
            check_all("goal4", 1, 0, 4, 0, 2, 0, 1);
         else
            check_all("goal5", 0, 1, 5, 0, 2, 1, 0);
      end

      // Goal and snitch for P1 plus a P2 goal, all in one cycle.
      restart("restart2", 1'b0);
      goal_p1 = 1'b1; snitch_p1 = 1'b1; goal_p2 = 1'b1;
      cyc();
      clear_events();
      check_all("mixed", 0, 1, 4, 1, 3, 1, 0);

      // Button held across restart and through the whole next match.
      restart("restart_held", 1'b1);
      wait_gameover("held_timeout", 30);
      check_all("held_end", 0, 1, 0, 0, 0, 3, 0);
      repeat (20) cyc();
      chk("no_retrigger.playing", 32'(playing_reg), 0);
      chk("no_retrigger.gameover", 32'(gameover_reg), 1);
      btn_start = 1'b0;
      cyc();
      btn_start = 1'b1;
      cyc();
      btn_start = 1'b0;
      check_all("new_edge", 1, 0, 0, 0, MS, 0, 0);

      // Asynchronous reset between clock edges.
      goal_p2 = 1'b1;
      cyc();
      clear_events();
      chk("pre_reset.score_p2", 32'(score_p2), 1);
      #3;
      reset = 1'b1;
      #1;
      check_all("async_reset", 0, 0, 0, 0, MS, 0, 0);
      cyc();
      reset = 1'b0;
      cyc();
      cyc();
      check_all("post_reset", 0, 0, 0, 0, MS, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
